uart_echo_responder: RTL and testbench
======================================

# uart_echo_responder

Byte-level responder on the far side of the UART core. It captures every byte the core's receiver delivers (`rx_done` / `data_received`) into a small FIFO. It then retransmits each byte, optionally transformed, through the core's transmitter handshake (`start_tx` / `data_in` / `tx_busy` / `tx_done`). Used as an on-chip loopback/echo peer for link bring-up and as the transmit-side counterpart of the receive path.

## Interface
- `DEPTH`, 8: FIFO depth in bytes; power of 2, ≥2.
- `ADDR_W`, 3: log2(DEPTH).

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: **synchronous, active-high** reset.
- `en` in 1: block enable.
- `mode` in 2: transform select. 00 echo, 01 bitwise invert, 10 ASCII uppercase, 11 add 1 mod 256.
- `clr_ovf` in 1: one-cycle pulse; clears `overflow`.
- `rx_done` in 1: one-cycle pulse from the UART receiver.
- `data_received` in 8: received byte, valid while `rx_done`=1.
- `tx_busy` in 1: UART transmitter busy.
- `tx_done` in 1: one-cycle pulse; transmitter finished its frame.
- `start_tx` out 1: one-cycle transmit request.
- `data_in` out 8: byte to transmit; registered.
- `count` out ADDR_W+1: FIFO occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a byte was dropped.
- `echo_busy` out 1: FSM not in IDLE.
- `bytes_echoed` out 16: completed transmissions; wraps 0xFFFF→0x0000.

## Operation
- Reset values: `start_tx`=0, `data_in`=0x00, `count`=0, `overflow`=0, `echo_busy`=0, `bytes_echoed`=0. FIFO pointers are 0 and the FSM is in IDLE. Reset applied mid-transfer aborts everything; the FIFO contents are discarded.
- Push: on an edge with `rx_done`=1 and `en`=1, write `data_received` at the tail.
  - If `count`==DEPTH and no pop occurs on the same edge, drop the byte and set `overflow`.
  - If a pop occurs on the same edge, accept the byte; `count` stays at DEPTH.
- Simultaneous push and pop with `count`≥1: both happen; `count` is unchanged.
- `en`=0: `rx_done` is ignored and no new pop starts. A transfer already in START/WAIT_DONE/GAP completes normally.
- `clr_ovf` clears `overflow`. If `clr_ovf` and a new drop occur on the same edge, the set wins.
- Pointers wrap modulo DEPTH. `count` carries the extra bit so full and empty are distinguishable.
- Transforms are applied at pop time using the `mode` value on that edge. For mode 10, bytes 0x61–0x7A become byte−0x20; all other bytes pass unchanged.
- FSM states and transitions:
  - IDLE → START when `en`=1, `count`≠0 and `tx_busy`=0. On that edge: pop the head, and load `data_in` with the transformed byte.
  - START → WAIT_DONE unconditionally. `start_tx`=1 only while in START.
  - WAIT_DONE → GAP on `tx_done`=1. On that edge, `bytes_echoed` increments.
  - GAP → IDLE unconditionally. This guarantees ≥1 idle cycle between frames.
- `data_in` holds its value from the pop edge until the next pop.
- A `tx_done` pulse seen outside WAIT_DONE is ignored.

## Timing
- Latency, empty FIFO and idle transmitter: `rx_done` sampled at edge E0 → `count`=1 after E0. The pop happens at E1. `start_tx`=1 for exactly the cycle between E1 and E2, with `data_in` already valid.
- `start_tx` is never high for two consecutive cycles.
- Minimum spacing between two `start_tx` pulses: 3 cycles plus the transmitter frame time.
- `echo_busy`=1 in START, WAIT_DONE and GAP.
- `count`, `overflow` and `bytes_echoed` update on the edge of the causing event and are visible the following cycle.

## Test plan
- **Basic echo:** mode 00, `rx_done` with 0xAB, `tx_busy`=0 → `start_tx` pulses 2 cycles after the sampling edge with `data_in`=0xAB. After `tx_done`: `bytes_echoed`=1, `echo_busy`=0 two cycles later.
- **Uppercase:** mode 10, bytes 0x61, 0x7A, 0x7B, 0x40 → transmitted 0x41, 0x5A, 0x7B, 0x40, in order. Each new `start_tx` occurs only after the previous `tx_done` plus GAP.
- **Invert and increment:** mode 01 with 0xA9 → 0x56. Mode 11 with 0xFF → 0x00. `mode` changed while in WAIT_DONE affects only the next pop.
- **Overflow:** DEPTH=8, `tx_busy` held at 1, push 0x00..0x08 → `count`=8, `overflow`=1, 0x08 dropped. Release `tx_busy` with normal `tx_done` responses → 0x00..0x07 echoed in order, final `count`=0. A `clr_ovf` pulse then clears `overflow`.
- **Boundaries:** with `count`=8, `rx_done` on the pop edge → byte accepted, `count` stays 8, no overflow. `clr_ovf` coincident with a drop → `overflow` stays 1. `bytes_echoed` preset via 65536 transfers wraps to 0.
- **Reset and enable:** `rst` asserted in WAIT_DONE with `count`=3 → next cycle all outputs at reset values, and a later `tx_done` is ignored. `en`=0 with `rx_done` pulses → `count` stays 0 and no `start_tx`.

Source files
------------

// File: rtl/uart_echo_responder.sv
// ---------------------------------------------------------------------------
// uart_echo_responder
//
// Echo peer for a UART core. Every byte delivered by the receiver is queued
// in a small FIFO and later retransmitted, optionally transformed, through
// the transmitter's request/busy/done handshake.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   en             block enable (gates new pushes and new pops)
//   mode[1:0]      transform: 00 echo, 01 invert, 10 ASCII upper, 11 +1
//   clr_ovf        pulse, clears the sticky overflow flag
//   rx_done        pulse, data_received holds a new byte
//   data_received  received byte
//   tx_busy        transmitter busy
//   tx_done        pulse, transmitter finished a frame
//   start_tx       one-cycle transmit request
//   data_in        registered byte presented to the transmitter
//   count          FIFO occupancy, 0..DEPTH
//   overflow       sticky, a byte was dropped on a full FIFO
//   echo_busy      FSM is not idle
//   bytes_echoed   completed transmissions, wraps at 16 bits
// ---------------------------------------------------------------------------
module uart_echo_responder #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic              clr_ovf,
   input  logic              rx_done,
   input  logic [7:0]        data_received,
   input  logic              tx_busy,
   input  logic              tx_done,
   output logic              start_tx,
   output logic [7:0]        data_in,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              echo_busy,
   output logic [15:0]       bytes_echoed
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

   state_t            state;
   state_t            state_nxt;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              push_req;
   logic              push;
   logic              pop;
   logic              drop;
   logic              frame_done;

   function automatic logic [7:0] transform(input logic [7:0] b, input logic [1:0] m);
      logic [7:0] r;
      case (m)
         2'b00:   r = b;
         2'b01:   r = ~b;
         2'b10:   r = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
         default: r = b + 8'd1;
      endcase
      return r;
   endfunction

   // A full FIFO still accepts a byte when the head leaves on the same edge.
   assign push_req = rx_done && en;
   assign push     = push_req && ((count != FULL_CNT) || pop);
   assign drop     = push_req && (count == FULL_CNT) && !pop;

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // ------------------------------------------------------------------
   // FSM next state and outputs
   // ------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      frame_done = 1'b0;
      start_tx   = 1'b0;
      echo_busy  = 1'b1;
      case (state)
         S_IDLE: begin
            echo_busy = 1'b0;
            if (en && (count != '0) && !tx_busy) begin
               pop       = 1'b1;
               state_nxt = S_START;
            end
         end
         S_START: begin
            start_tx  = 1'b1;
            state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (tx_done) begin
               frame_done = 1'b1;
               state_nxt  = S_GAP;
            end
         end
         // Forces at least one idle cycle between consecutive frames.
         S_GAP:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FIFO storage
   // ------------------------------------------------------------------
   // NOTE: the byte array has no reset; emptiness is tracked by the pointers
   // and count, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_received;
   end

   // ------------------------------------------------------------------
   // Pointers, occupancy, flags, output byte and frame counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         data_in      <= 8'h00;
         bytes_echoed <= 16'h0000;
      end else begin
         if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + ADDR_W'(1);
            data_in <= transform(mem[rd_ptr], mode);
         end

         case ({push, pop})
            2'b10:   count <= count + (ADDR_W + 1)'(1);
            2'b01:   count <= count - (ADDR_W + 1)'(1);
            default: count <= count;
         endcase

         // A drop on the same edge as clr_ovf keeps the flag set.
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;

         if (frame_done) bytes_echoed <= bytes_echoed + 16'd1;
      end
   end

endmodule

// File: tb/tb_uart_echo_responder.sv
// ---------------------------------------------------------------------------
// Self-checking bench for uart_echo_responder. A transmitter model answers
// start_tx with busy/done; a monitor compares every transmitted byte against
// a queue of expected bytes filled when stimulus is driven.
// ---------------------------------------------------------------------------
module tb_uart_echo_responder;

   logic        clk;
   logic        rst;
   logic        en;
   logic [1:0]  mode;
   logic        clr_ovf;
   logic        rx_done;
   logic [7:0]  data_received;
   logic        tx_busy;
   logic        tx_done;
   logic        start_tx;
   logic [7:0]  data_in;
   logic [3:0]  count;
   logic        overflow;
   logic        echo_busy;
   logic [15:0] bytes_echoed;

   logic        tx_hold;
   logic        model_busy;
   logic        model_done;
   logic        manual_done;
   bit          model_en;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          last_done_cyc = -1;
   int          exp_echoed = 0;
   logic [7:0]  exp_q [$];

   assign tx_busy = tx_hold | model_busy;
   assign tx_done = model_done | manual_done;

   uart_echo_responder #(.DEPTH(8), .ADDR_W(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .mode         (mode),
      .clr_ovf      (clr_ovf),
      .rx_done      (rx_done),
      .data_received(data_received),
      .tx_busy      (tx_busy),
      .tx_done      (tx_done),
      .start_tx     (start_tx),
      .data_in      (data_in),
      .count        (count),
      .overflow     (overflow),
      .echo_busy    (echo_busy),
      .bytes_echoed (bytes_echoed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Transmitter model: busy for three cycles, then a one-cycle done pulse.
   initial begin
      model_busy = 1'b0;
      model_done = 1'b0;
      forever begin
         @(negedge clk);
         if (start_tx && model_en) begin
            model_busy = 1'b1;
            repeat (3) @(negedge clk);
            model_busy    = 1'b0;
            model_done    = 1'b1;
            last_done_cyc = cyc;
            exp_echoed++;
            @(negedge clk);
            model_done = 1'b0;
         end
      end
   end

   // Scoreboard monitor: every start_tx pops one expected byte.
   initial begin
      logic prev_start;
      prev_start = 1'b0;
      forever begin
         @(negedge clk);
         if (start_tx) begin
            check("start_tx_not_back_to_back", {31'b0, prev_start}, 32'd0);
            if (last_done_cyc >= 0)
               check("gap_after_tx_done", {31'b0, (cyc - last_done_cyc) >= 3}, 32'd1);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_start_tx: got data_in %0h expected no transmission", data_in);
            end else begin
               check("tx_byte", {24'b0, data_in}, {24'b0, exp_q.pop_front()});
            end
         end
         prev_start = start_tx;
      end
   end

   // Drive one received byte for one cycle; call right after a negedge.
   task automatic send(input logic [7:0] b, input logic [7:0] exp_b, input bit expect_tx);
      rx_done       = 1'b1;
      data_received = b;
      if (expect_tx) exp_q.push_back(exp_b);
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic drain(input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (count == 4'd0 && !echo_busy && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check(nm, {31'b0, ok}, 32'd1);
      check({nm, "_bytes_echoed"}, {16'b0, bytes_echoed}, exp_echoed);
   endtask

   task automatic wait_start(input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (start_tx) begin
            ok = 1'b1;
            break;
         end
      end
      check(nm, {31'b0, ok}, 32'd1);
   endtask

   typedef struct {
      logic [1:0] mode;
      logic [7:0] din;
      logic [7:0] dout;
   } vec_t;

   vec_t vecs [10];

   initial begin
      bit found;

      vecs[0] = '{2'b00, 8'hAB, 8'hAB};
      vecs[1] = '{2'b10, 8'h61, 8'h41};
      vecs[2] = '{2'b10, 8'h7A, 8'h5A};
      vecs[3] = '{2'b10, 8'h7B, 8'h7B};
      vecs[4] = '{2'b10, 8'h40, 8'h40};
      vecs[5] = '{2'b10, 8'h60, 8'h60};
      vecs[6] = '{2'b01, 8'hA9, 8'h56};
      vecs[7] = '{2'b01, 8'h00, 8'hFF};
      vecs[8] = '{2'b11, 8'hFF, 8'h00};
      vecs[9] = '{2'b11, 8'h41, 8'h42};

      rst = 1'b1; en = 1'b1; mode = 2'b00; clr_ovf = 1'b0;
      rx_done = 1'b0; data_received = 8'h00;
      tx_hold = 1'b0; manual_done = 1'b0; model_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_start_tx",     {31'b0, start_tx},      32'd0);
      check("reset_data_in",      {24'b0, data_in},       32'd0);
      check("reset_count",        {28'b0, count},         32'd0);
      check("reset_overflow",     {31'b0, overflow},      32'd0);
      check("reset_echo_busy",    {31'b0, echo_busy},     32'd0);
      check("reset_bytes_echoed", {16'b0, bytes_echoed},  32'd0);

      // Transform table; same-mode runs are queued back-to-back to check order.
      for (int i = 0; i < 10; i++) begin
         mode = vecs[i].mode;
         send(vecs[i].din, vecs[i].dout, 1'b1);
         if (i == 9 || vecs[i+1].mode != vecs[i].mode) drain($sformatf("vec_drain_%0d", i));
      end

      // Basic echo latency: start_tx two cycles after the sampling edge.
      mode = 2'b00;
      exp_echoed = exp_echoed;
      rx_done = 1'b1; data_received = 8'hAB; exp_q.push_back(8'hAB);
      @(negedge clk);
      rx_done = 1'b0;
      check("lat_count_after_e0", {28'b0, count},    32'd1);
      check("lat_no_start_e0",    {31'b0, start_tx}, 32'd0);
      @(negedge clk);
      check("lat_start_e1",       {31'b0, start_tx}, 32'd1);
      check("lat_data_in_e1",     {24'b0, data_in},  32'hAB);
      check("lat_count_e1",       {28'b0, count},    32'd0);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         if (tx_done) begin
            found = 1'b1;
            break;
         end
      end
      check("basic_tx_done_seen", {31'b0, found}, 32'd1);
      #1;
      check("basic_echoed_after_done", {16'b0, bytes_echoed}, exp_echoed);
      check("basic_busy_in_gap",       {31'b0, echo_busy},    32'd1);
      @(posedge clk); #1;
      check("basic_idle_after_gap",    {31'b0, echo_busy},    32'd0);
      check("basic_data_in_held",      {24'b0, data_in},      32'hAB);
      @(negedge clk);

      // Mode change during WAIT_DONE only affects the next pop.
      mode = 2'b00;
      send(8'h10, 8'h10, 1'b1);
      wait_start("modechg_start");
      @(negedge clk);
      mode = 2'b01;
      send(8'h10, 8'hEF, 1'b1);
      drain("modechg_drain");

      // Overflow with the transmitter held busy.
      mode = 2'b00;
      tx_hold = 1'b1;
      for (int i = 0; i < 9; i++) begin
         rx_done = 1'b1;
         data_received = 8'(i);
         if (i < 8) exp_q.push_back(8'(i));
         @(negedge clk);
      end
      rx_done = 1'b0;
      check("ovf_count_full", {28'b0, count},    32'd8);
      check("ovf_set",        {31'b0, overflow}, 32'd1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("ovf_cleared", {31'b0, overflow}, 32'd0);
      rx_done = 1'b1; data_received = 8'h09; clr_ovf = 1'b1;
      @(negedge clk);
      rx_done = 1'b0; clr_ovf = 1'b0;
      check("ovf_set_wins_over_clr", {31'b0, overflow}, 32'd1);
      check("ovf_count_still_full",  {28'b0, count},    32'd8);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      // Push on the pop edge with a full FIFO is accepted.
      tx_hold = 1'b0;
      rx_done = 1'b1; data_received = 8'h55; exp_q.push_back(8'h55);
      @(negedge clk);
      rx_done = 1'b0;
      check("full_pushpop_count",    {28'b0, count},     32'd8);
      check("full_pushpop_no_ovf",   {31'b0, overflow},  32'd0);
      check("full_pushpop_start",    {31'b0, start_tx},  32'd1);
      drain("ovf_drain");
      check("ovf_final_count", {28'b0, count}, 32'd0);

      // Enable: ignored rx while disabled, no new pop, in-flight completes.
      en = 1'b0;
      for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i), 8'h00, 1'b0);
      repeat (4) @(negedge clk);
      check("en0_count_zero", {28'b0, count},     32'd0);
      check("en0_idle",       {31'b0, echo_busy}, 32'd0);
      en = 1'b1; tx_hold = 1'b1;
      send(8'h33, 8'h33, 1'b1);
      en = 1'b0; tx_hold = 1'b0;
      repeat (5) @(negedge clk);
      check("en0_no_pop_count", {28'b0, count},     32'd1);
      check("en0_no_pop_idle",  {31'b0, echo_busy}, 32'd0);
      en = 1'b1;
      wait_start("en_resume_start");
      en = 1'b0;
      repeat (8) @(negedge clk);
      check("en0_inflight_done", {16'b0, bytes_echoed}, exp_echoed);
      en = 1'b1;
      drain("en_drain");

      // Reset in WAIT_DONE with three bytes still queued.
      model_en = 1'b0;
      tx_hold  = 1'b1;
      send(8'h01, 8'h01, 1'b1);
      send(8'h02, 8'h00, 1'b0);
      send(8'h03, 8'h00, 1'b0);
      send(8'h04, 8'h00, 1'b0);
      tx_hold = 1'b0;
      wait_start("rst_start");
      @(negedge clk);
      check("rst_pre_count", {28'b0, count},     32'd3);
      check("rst_pre_busy",  {31'b0, echo_busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_echoed = 0;
      check("rst_mid_start_tx",     {31'b0, start_tx},     32'd0);
      check("rst_mid_data_in",      {24'b0, data_in},      32'd0);
      check("rst_mid_count",        {28'b0, count},        32'd0);
      check("rst_mid_overflow",     {31'b0, overflow},     32'd0);
      check("rst_mid_echo_busy",    {31'b0, echo_busy},    32'd0);
      check("rst_mid_bytes_echoed", {16'b0, bytes_echoed}, 32'd0);
      manual_done = 1'b1;
      @(negedge clk);
      manual_done = 1'b0;
      @(negedge clk);
      check("late_done_ignored", {16'b0, bytes_echoed}, 32'd0);
      check("late_done_idle",    {31'b0, echo_busy},    32'd0);
      model_en = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_fifo_discarded", {28'b0, count}, 32'd0);
      mode = 2'b11;
      send(8'h77, 8'h78, 1'b1);
      drain("post_rst_drain");

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
